// File: rtl/score_display_pkg.sv
// Shared types, segment table and helpers for the score display.
package score_display_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    COMMIT
  } conv_state_t;

  // bit 0 = A ... bit 6 = G; codes 10..15 are dark
  localparam logic [6:0] SEG_LUT [16] = '{
    7'h3f, 7'h06, 7'h5b, 7'h4f,
    7'h66, 7'h6d, 7'h7d, 7'h07,
    7'h7f, 7'h6f, 7'h00, 7'h00,
    7'h00, 7'h00, 7'h00, 7'h00
  };

  function automatic int unsigned pow10(input int unsigned n);
    int unsigned r;
    r = 1;
    for (int unsigned i = 0; i < n; i++)
      r = r * 10;
    return r;
  endfunction

endpackage

// File: rtl/seven_seg_glyph.sv
// Combinational hit test of one seven-segment glyph at a fixed origin.
module seven_seg_glyph
  import score_display_pkg::*;
#(
  parameter int OX = 0,
  parameter int OY = 0,
  parameter int W  = 32,
  parameter int H  = 60,
  parameter int T  = 6
) (
  input  logic [9:0] Q_X,
  input  logic [9:0] Q_Y,
  input  logic [3:0] code,
  output logic       hit
);

  localparam int M = H / 2;

  logic [10:0] x;
  logic [10:0] y;
  logic [6:0]  seg;
  logic xl, xm, xr;
  logic ya, yu, yl, yd, yg;

  function automatic logic inr(
    input logic [10:0] v,
    input int lo,
    input int hi
  );
    return (v >= 11'(lo)) && (v < 11'(hi));
  endfunction

  assign x   = {1'b0, Q_X};
  assign y   = {1'b0, Q_Y};
  assign seg = SEG_LUT[code];

  assign xl = inr(x, OX, OX + T);
  assign xm = inr(x, OX + T, OX + W - T);
  assign xr = inr(x, OX + W - T, OX + W);

  assign ya = inr(y, OY, OY + T);
  assign yu = inr(y, OY + T, OY + M);
  assign yl = inr(y, OY + M, OY + H - T);
  assign yd = inr(y, OY + H - T, OY + H);
  assign yg = inr(y, OY + M - T / 2, OY + M + T - T / 2);

  assign hit = (seg[0] & xm & ya)
             | (seg[1] & xr & yu)
             | (seg[2] & xr & yl)
             | (seg[3] & xm & yd)
             | (seg[4] & xl & yl)
             | (seg[5] & xl & yu)
             | (seg[6] & xm & yg);

endmodule

// File: rtl/multi_digit_score_display.sv
// Per-frame binary-to-BCD score renderer with tear-free digit register.
// Optional: define LEADING_ZERO_BLANK_EN to blank leading zero digits.
module multi_digit_score_display
  import score_display_pkg::*;
#(
  parameter int X           = 0,
  parameter int Y           = 0,
  parameter int NUM_DIGITS  = 4,
  parameter int VALUE_W     = 14,
  parameter int DIGIT_W     = 32,
  parameter int DIGIT_H     = 60,
  parameter int SEG_T       = 6,
  parameter int DIGIT_PITCH = 44
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_start,
  input  logic [VALUE_W-1:0] value,
  input  logic [9:0]         Q_X,
  input  logic [9:0]         Q_Y,
  output logic               visible,
  output logic               busy,
  output logic               overflow
);

  localparam int BW = NUM_DIGITS * 4;
  localparam int CW = $clog2(VALUE_W + 1);
  localparam logic [31:0] MAXV = 32'(pow10(NUM_DIGITS) - 1);

  conv_state_t        state;
  logic [BW-1:0]      bcd;
  logic [BW-1:0]      adj;
  logic [BW-1:0]      disp;
  logic [VALUE_W-1:0] bin;
  logic [CW-1:0]      cnt;
  logic               sat;
  logic               clamp;
  logic [3:0]         codes [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] hits;

  assign clamp = 32'(value) > MAXV;
  assign busy  = (state != IDLE);

  always_comb begin
    adj = bcd;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (bcd[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      bcd      <= '0;
      bin      <= '0;
      cnt      <= '0;
      sat      <= 1'b0;
      disp     <= '0;
      overflow <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (frame_start) begin
            bin   <= clamp ? MAXV[VALUE_W-1:0] : value;
            sat   <= clamp;
            bcd   <= '0;
            cnt   <= '0;
            state <= CONVERT;
          end
        end
        CONVERT: begin
          {bcd, bin} <= {adj, bin} << 1;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(VALUE_W - 1))
            state <= COMMIT;
        end
        COMMIT: begin
          disp     <= bcd;
          overflow <= sat;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic lead;

  // the last digit always shows, so a zero value reads "0"
  always_comb begin
    lead = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      codes[i] = disp[4*(NUM_DIGITS-1-i) +: 4];
      if (lead && codes[i] == 4'd0 && i != NUM_DIGITS - 1)
        codes[i] = 4'hf;
      else
        lead = 1'b0;
    end
  end
`else
  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++)
      codes[i] = disp[4*(NUM_DIGITS-1-i) +: 4];
  end
`endif

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
    seven_seg_glyph #(
      .OX(X + i * DIGIT_PITCH),
      .OY(Y),
      .W (DIGIT_W),
      .H (DIGIT_H),
      .T (SEG_T)
    ) u_glyph (
      .Q_X (Q_X),
      .Q_Y (Q_Y),
      .code(codes[i]),
      .hit (hits[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) visible <= 1'b0;
    else     visible <= |hits;
  end

endmodule

// File: tb/tb_multi_digit_score_display.sv
// Scoreboard bench for multi_digit_score_display at default parameters.
module tb_multi_digit_score_display;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_start;
  logic [13:0] value;
  logic [9:0]  qx;
  logic [9:0]  qy;
  logic        visible;
  logic        busy;
  logic        overflow;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int   val;
    logic ovf;
  } exp_t;

  exp_t sbq[$];
  int   px[7];
  int   py[7];

  always #5 clk = ~clk;

  multi_digit_score_display dut (
    .clk        (clk),
    .rst        (rst),
    .frame_start(frame_start),
    .value      (value),
    .Q_X        (qx),
    .Q_Y        (qy),
    .visible    (visible),
    .busy       (busy),
    .overflow   (overflow)
  );

  // {A,B,C,D,E,F,G}, A in the MSB
  function automatic logic [6:0] exp_seg(input int d);
    case (d)
      0: return 7'b1111110;
      1: return 7'b0110000;
      2: return 7'b1101101;
      3: return 7'b1111001;
      4: return 7'b0110011;
      5: return 7'b1011011;
      6: return 7'b1011111;
      7: return 7'b1110000;
      8: return 7'b1111111;
      9: return 7'b1111011;
      default: return 7'b0000000;
    endcase
  endfunction

  task automatic pix(input int x, input int y, output logic v);
    @(negedge clk);
    qx = 10'(x);
    qy = 10'(y);
    @(posedge clk);
    #1 v = visible;
  endtask

  task automatic check_pix(input int x, input int y,
                           input logic want, input string tag);
    logic v;
    pix(x, y, v);
    total++;
    if (v !== want) begin
      bad++;
      $display("FAIL %s pixel(%0d,%0d) got=%b want=%b", tag, x, y, v, want);
    end
  endtask

  task automatic check_display(input int val, input string tag);
    logic [6:0] got;
    logic [6:0] want;
    logic       v;
    int         d;
    int         p;
    bit         lead;
    p    = 1000;
    lead = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d    = (val / p) % 10;
      p    = p / 10;
      want = exp_seg(d);
`ifdef LEADING_ZERO_BLANK_EN
      if (lead && d == 0 && i != 3) want = 7'b0;
      else lead = 1'b0;
`endif
      for (int s = 0; s < 7; s++) begin
        pix(i * 44 + px[s], py[s], v);
        got[6-s] = v;
      end
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL %s digit%0d segs got=%b want=%b", tag, i, got, want);
      end
    end
  endtask

  task automatic start_frame(input int val, input bit push);
    exp_t e;
    @(negedge clk);
    value       = 14'(val);
    frame_start = 1'b1;
    if (push) begin
      e.val = (val > 9999) ? 9999 : val;
      e.ovf = (val > 9999);
      sbq.push_back(e);
    end
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    exp_t e;
    int   n;
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL %s busy_start got=%b want=1", tag, busy);
    end
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      @(posedge clk);
      #1 n++;
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL %s timeout busy got=%b want=0", tag, busy);
    end
    total++;
    if (sbq.size() == 0) begin
      bad++;
      $display("FAIL %s scoreboard empty got=0 want>0", tag);
    end else begin
      e = sbq.pop_front();
      total++;
      if (overflow !== e.ovf) begin
        bad++;
        $display("FAIL %s overflow got=%b want=%b", tag, overflow, e.ovf);
      end
      check_display(e.val, tag);
    end
  endtask

  task automatic check_idle(input string tag);
    total++;
    if (visible !== 1'b0 || busy !== 1'b0 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL %s vis/busy/ovf got=%b%b%b want=000",
               tag, visible, busy, overflow);
    end
  endtask

  task automatic test_reset();
    rst         = 1'b1;
    frame_start = 1'b0;
    value       = '0;
    qx          = '0;
    qy          = '0;
    repeat (3) @(posedge clk);
    #1 check_idle("reset");
    @(negedge clk);
    rst = 1'b0;
    check_display(0, "reset_disp");
  endtask

  task automatic test_basic();
    start_frame(1234, 1'b1);
    wait_done("v1234");
    check_pix(5, 2, 1'b0, "d0_segA_off");
    check_pix(44 + 16, 2, 1'b1, "d1_segA_on");
  endtask

  task automatic test_overflow();
    start_frame(10000, 1'b1);
    wait_done("sat10000");
    start_frame(42, 1'b1);
    wait_done("v42");
  endtask

  task automatic test_back_to_back();
    start_frame(11, 1'b1);
    repeat (3) @(negedge clk);
    @(negedge clk);
    value       = 14'd22;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    wait_done("b2b");
    repeat (20) @(posedge clk);
    #1;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL no_queue busy got=%b want=0", busy);
    end
  endtask

  task automatic test_reset_mid();
    start_frame(10000, 1'b1);
    wait_done("pre_rst");
    start_frame(5678, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_idle("reset_mid");
    rst = 1'b0;
    check_display(0, "reset_mid_disp");
  endtask

  task automatic test_blank();
    start_frame(7, 1'b1);
    wait_done("v7");
    start_frame(0, 1'b1);
    wait_done("v0");
  endtask

  task automatic test_pixel();
    start_frame(8888, 1'b1);
    wait_done("v8888");
    check_pix(16, 15, 1'b0, "interior");
    @(negedge clk);
    qx = 10'd16;
    qy = 10'd30;
    #1;
    total++;
    if (visible !== 1'b0) begin
      bad++;
      $display("FAIL latency_early got=%b want=0", visible);
    end
    @(posedge clk);
    #1;
    total++;
    if (visible !== 1'b1) begin
      bad++;
      $display("FAIL latency_segG got=%b want=1", visible);
    end
    check_pix(32, 30, 1'b0, "gap");
    check_pix(31, 15, 1'b1, "segB_edge");
    check_pix(16, 26, 1'b0, "segG_above");
    check_pix(16, 27, 1'b1, "segG_top");
    check_pix(16, 33, 1'b0, "segG_below");
    check_pix(132 + 31, 57, 1'b0, "segD_end");
    check_pix(132 + 25, 59, 1'b1, "segD_last");
    check_pix(1023, 30, 1'b0, "x1023");
  endtask

  initial begin
    px = '{16, 29, 29, 16, 2, 2, 16};
    py = '{2, 15, 45, 57, 45, 15, 30};
    test_reset();
    test_basic();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    test_blank();
    test_pixel();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
